// File: rtl/acx_axi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : acx_axi_reg_bridge
// Purpose  : AXI4-Lite slave to simple register bus, one transaction in flight,
//            hit-decoded slave response with timeout and multi-hit detection.
// Revision : 1.0 - initial release
// ============================================================================
module acx_axi_reg_bridge #(
    parameter int                        TGT_ADDR_WIDTH = 28,
    parameter int                        TGT_DATA_WIDTH = 32,
    parameter int                        NUM_REGS       = 8,
    parameter int                        TIMEOUT        = 16,
    parameter logic [TGT_DATA_WIDTH-1:0] TIMEOUT_DATA   = TGT_DATA_WIDTH'(32'hDEAD0BAD)
) (
    input  logic                               i_clk,
    input  logic                               i_rstn,
    input  logic                               i_awvalid,
    output logic                               o_awready,
    input  logic [TGT_ADDR_WIDTH-1:0]          i_awaddr,
    input  logic                               i_wvalid,
    output logic                               o_wready,
    input  logic [TGT_DATA_WIDTH-1:0]          i_wdata,
    input  logic [TGT_DATA_WIDTH/8-1:0]        i_wstrb,
    output logic                               o_bvalid,
    input  logic                               i_bready,
    output logic [1:0]                         o_bresp,
    input  logic                               i_arvalid,
    output logic                               o_arready,
    input  logic [TGT_ADDR_WIDTH-1:0]          i_araddr,
    output logic                               o_rvalid,
    input  logic                               i_rready,
    output logic [TGT_DATA_WIDTH-1:0]          o_rdata,
    output logic [1:0]                         o_rresp,
    output logic                               o_rd,
    output logic                               o_wr,
    output logic [TGT_ADDR_WIDTH-1:0]          o_addr,
    output logic [TGT_DATA_WIDTH-1:0]          o_wr_data,
    input  logic [NUM_REGS-1:0]                i_addr_hit,
    input  logic [NUM_REGS*TGT_DATA_WIDTH-1:0] i_rd_data
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    localparam logic [7:0] c_CNT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] c_CNT_EVAL  = 8'd2;
    localparam logic [1:0] c_RESP_OKAY = 2'b00;
    localparam logic [1:0] c_RESP_SLV  = 2'b10;
    localparam logic [1:0] c_RESP_DEC  = 2'b11;

    state_t                      r_state;
    logic [7:0]                  r_cnt;
    logic                        r_prio_wr;

    logic                        w_idle;
    logic                        w_wr_req;
    logic                        w_grant_rd;
    logic                        w_grant_wr;
    logic                        w_hit_any;
    logic                        w_hit_multi;
    logic [TGT_DATA_WIDTH-1:0]   w_hit_data;
    logic                        w_done;
    logic [1:0]                  w_resp;
    logic [TGT_DATA_WIDTH-1:0]   w_resp_data;
    logic                        w_unused_wstrb;

    assign w_unused_wstrb = ^i_wstrb;

    // Ready lines are combinational so a request is taken in the very first
    // cycle after reset release; the losing channel is held off so that no
    // handshake completes without being served.
    assign w_idle     = (r_state == ST_IDLE) && i_rstn;
    assign w_wr_req   = i_awvalid && i_wvalid;
    assign w_grant_rd = w_idle && i_arvalid && (!w_wr_req || !r_prio_wr);
    assign w_grant_wr = w_idle && w_wr_req && (!i_arvalid || r_prio_wr);
    assign o_arready  = w_idle && !w_grant_wr;
    assign o_awready  = w_grant_wr;
    assign o_wready   = w_grant_wr;

    always_comb begin
        w_hit_any   = 1'b0;
        w_hit_multi = 1'b0;
        w_hit_data  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (i_addr_hit[k]) begin
                w_hit_multi = w_hit_multi || w_hit_any;
                w_hit_any   = 1'b1;
                w_hit_data  = w_hit_data | i_rd_data[k*TGT_DATA_WIDTH +: TGT_DATA_WIDTH];
            end
        end
    end

    // Hits in the first two WAIT cycles still reflect the previous address.
    assign w_done      = ((r_cnt >= c_CNT_EVAL) && w_hit_any) || (r_cnt == c_CNT_LAST);
    assign w_resp      = !w_hit_any ? c_RESP_SLV : (w_hit_multi ? c_RESP_DEC : c_RESP_OKAY);
    assign w_resp_data = (w_hit_any && !w_hit_multi) ? w_hit_data : TIMEOUT_DATA;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_prio_wr <= 1'b0;
            o_rd      <= 1'b0;
            o_wr      <= 1'b0;
            o_rvalid  <= 1'b0;
            o_bvalid  <= 1'b0;
            o_addr    <= '0;
            o_wr_data <= '0;
            o_rdata   <= '0;
            o_rresp   <= 2'b00;
            o_bresp   <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_rd) begin
                        o_addr    <= i_araddr;
                        o_rd      <= 1'b1;
                        r_cnt     <= '0;
                        r_prio_wr <= !r_prio_wr;
                        r_state   <= ST_RD_WAIT;
                    end else if (w_grant_wr) begin
                        o_addr    <= i_awaddr;
                        o_wr_data <= i_wdata;
                        o_wr      <= 1'b1;
                        r_cnt     <= '0;
                        r_prio_wr <= !r_prio_wr;
                        r_state   <= ST_WR_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (w_done) begin
                        o_rd     <= 1'b0;
                        o_rvalid <= 1'b1;
                        o_rresp  <= w_resp;
                        o_rdata  <= w_resp_data;
                        r_state  <= ST_RD_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_WR_WAIT: begin
                    if (w_done) begin
                        o_wr     <= 1'b0;
                        o_bvalid <= 1'b1;
                        o_bresp  <= w_resp;
                        r_state  <= ST_WR_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RD_RESP: begin
                    if (i_rready) begin
                        o_rvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_WR_RESP: begin
                    if (i_bready) begin
                        o_bvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acx_axi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_acx_axi_reg_bridge
// Purpose  : Directed self-checking bench with a 2-stage register slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acx_axi_reg_bridge;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic         bready = 1'b0, rready = 1'b0;
    logic [27:0]  awaddr = '0, araddr = '0;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = 4'hF;
    logic         awready, wready, arready, bvalid, rvalid, rd, wr;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata, wr_data;
    logic [27:0]  addr;
    logic [7:0]   dec = '0;
    logic [7:0]   hit = '0;
    logic [255:0] rd_data;

    int n_assert = 0;
    int n_fail   = 0;
    int lat, strobes;

    always #5 clk = ~clk;

    acx_axi_reg_bridge dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr),
        .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
        .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
        .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
        .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp),
        .o_rd(rd), .o_wr(wr), .o_addr(addr), .o_wr_data(wr_data),
        .i_addr_hit(hit), .i_rd_data(rd_data)
    );

    // Slave model: registered decode, then registered hit
    function automatic logic [7:0] decode(input logic [27:0] a);
        case (a)
            28'h10:  decode = 8'b0000_0100;
            28'h20:  decode = 8'b0000_0001;
            28'h30:  decode = 8'b0000_1010;
            28'h40:  decode = 8'b0010_0000;
            default: decode = 8'b0000_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        dec <= decode(addr);
        hit <= dec;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called one cycle after the handshake edge; lat counts cycles from the handshake cycle
    task automatic wait_done(input bit is_rd, output int l, output int s);
        l = 1;
        s = 0;
        while (!(is_rd ? rvalid : bvalid) && l < 80) begin
            if (is_rd ? rd : wr) s++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic ack(input bit is_rd, input string tag);
        if (is_rd) rready = 1'b1; else bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        bready = 1'b0;
        chk(tag, {31'd0, is_rd ? rvalid : bvalid}, 32'd0);
    endtask

    task automatic read_txn(input logic [27:0] a, input logic [31:0] ed, input logic [1:0] er,
                            input int elat, input string tag);
        arvalid = 1'b1; araddr = a;
        #1 chk({tag, "_arready"}, {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_done(1'b1, lat, strobes);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_rd_cycles"}, strobes, elat - 1);
        chk({tag, "_rdata"}, rdata, ed);
        chk({tag, "_rresp"}, {30'd0, rresp}, {30'd0, er});
    endtask

    initial begin
        for (int k = 0; k < 8; k++) rd_data[k*32 +: 32] = 32'hC0DE_0000 + k;
        rd_data[64 +: 32] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_valids", {28'd0, rvalid, bvalid, rd, wr}, 32'd0);
        chk("rst_addr", {4'd0, addr}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resps", {28'd0, rresp, bresp}, 32'd0);

        // Read and write offered together straight out of reset: read wins
        rstn = 1'b1;
        arvalid = 1'b1; araddr = 28'h10;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 28'h50; wdata = 32'h0BAD_F00D;
        #1;
        chk("pair1_arready", {31'd0, arready}, 32'd1);
        chk("pair1_awready", {30'd0, awready, wready}, 32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_done(1'b1, lat, strobes);
        chk("pair1_rd_lat", lat, 4);
        chk("pair1_rd_cycles", strobes, 3);
        chk("pair1_rdata", rdata, 32'h1234_5678);
        chk("pair1_rresp", {30'd0, rresp}, 32'd0);
        chk("pair1_addr", {4'd0, addr}, 32'h10);
        ack(1'b1, "pair1_rvalid_clr");
        chk("pair1_awready_after", {30'd0, awready, wready}, 32'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        // Stale slave-2 hit must not complete this unmapped write
        wait_done(1'b0, lat, strobes);
        chk("pair1_wr_lat", lat, 17);
        chk("pair1_wr_cycles", strobes, 16);
        chk("pair1_bresp", {30'd0, bresp}, 32'd2);
        ack(1'b0, "pair1_bvalid_clr");

        // Plain write to slave 0
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 28'h20; wdata = 32'hA5A5_A5A5; wstrb = 4'h1;
        #1 chk("wr_awready", {30'd0, awready, wready}, 32'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_strobe", {31'd0, wr}, 32'd1);
        chk("wr_data", wr_data, 32'hA5A5_A5A5);
        wait_done(1'b0, lat, strobes);
        chk("wr_lat", lat, 4);
        chk("wr_cycles", strobes, 3);
        chk("wr_bresp", {30'd0, bresp}, 32'd0);
        chk("wr_addr", {4'd0, addr}, 32'h20);
        ack(1'b0, "wr_bvalid_clr");

        // Three grants so far leave write priority: write first this time
        arvalid = 1'b1; araddr = 28'h30;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 28'h40; wdata = 32'h5555_0001;
        #1;
        chk("pair2_arready", {31'd0, arready}, 32'd0);
        chk("pair2_awready", {30'd0, awready, wready}, 32'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_done(1'b0, lat, strobes);
        chk("pair2_wr_lat", lat, 4);
        chk("pair2_bresp", {30'd0, bresp}, 32'd0);
        ack(1'b0, "pair2_bvalid_clr");
        chk("pair2_arready_after", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_done(1'b1, lat, strobes);
        chk("decerr_lat", lat, 4);
        chk("decerr_rresp", {30'd0, rresp}, 32'd3);
        chk("decerr_rdata", rdata, 32'hDEAD_0BAD);
        ack(1'b1, "decerr_rvalid_clr");

        read_txn(28'h60, 32'hDEAD_0BAD, 2'b10, 17, "timeout");
        ack(1'b1, "timeout_rvalid_clr");

        // Response stalled, then aborted by reset
        read_txn(28'h40, 32'hC0DE_0005, 2'b00, 4, "stall");
        repeat (10) @(posedge clk);
        #1;
        chk("stall_rvalid_held", {31'd0, rvalid}, 32'd1);
        chk("stall_rdata_held", rdata, 32'hC0DE_0005);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("abort_rvalid", {31'd0, rvalid}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_addr", {4'd0, addr}, 32'd0);
        rstn = 1'b1;
        read_txn(28'h10, 32'h1234_5678, 2'b00, 4, "post_rst");
        ack(1'b1, "post_rst_rvalid_clr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
